// File: rtl/seq_div_nr.sv
// seq_div_nr: sequential radix-2 restoring divider.
// Divides a 2W-bit dividend by a W-bit divisor, one quotient bit per cycle,
// with valid/ready handshakes on the operand and result sides.
module seq_div_nr #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero,
    output logic           ovf
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    p;      // partial remainder; always < d, so its top bit is implicit 0
    logic [W-1:0]    sh;     // dividend low half shifts out MSB-first, quotient bits shift in
    logic [W-1:0]    d;
    logic [CW-1:0]   cnt;

    logic [W:0]      trial;
    logic [W:0]      p_next;
    logic            qbit;

    // One restoring step: trial subtract with W+1-bit borrow detection
    always_comb begin
        trial  = {p, sh[W-1]} - {1'b0, d};
        qbit   = ~trial[W];
        p_next = qbit ? trial : {p, sh[W-1]};
    end

    // Control FSM and datapath registers, all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
            p         <= '0;
            sh        <= '0;
            d         <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            state     <= DONE;
                            div_zero  <= 1'b1;
                            ovf       <= 1'b0;
                            quotient  <= '1;
                            remainder <= '0;
                        end else if (dividend[2*W-1:W] >= divisor) begin
                            state     <= DONE;
                            div_zero  <= 1'b0;
                            ovf       <= 1'b1;
                            quotient  <= '1;
                            remainder <= '0;
                        end else begin
                            state <= CALC;
                            p     <= dividend[2*W-1:W];
                            sh    <= dividend[W-1:0];
                            d     <= divisor;
                            cnt   <= CW'(W);
                        end
                    end
                end
                CALC: begin
                    p   <= p_next[W-1:0];
                    sh  <= {sh[W-2:0], qbit};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= {sh[W-2:0], qbit};
                        remainder <= p_next[W-1:0];
                        div_zero  <= 1'b0;
                        ovf       <= 1'b0;
                    end
                end
                DONE: begin
                    // Exceptions enter DONE with out_valid low so it rises one edge after accept
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_nr.sv
// tb_seq_div_nr: scoreboard bench for seq_div_nr (W=4).
module tb_seq_div_nr;

    localparam int W = 4;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_zero;
    logic           ovf;

    seq_div_nr #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Result monitor: a result is handed off at the next rising edge
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quotient",  32'(quotient),  32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_zero",  32'(div_zero),  32'(e.dz));
                check("ovf",       32'(ovf),       32'(e.ov));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    endtask

    // Apply one operation, push its expectation, and check result latency
    task automatic run_op(input logic [2*W-1:0] n, input logic [W-1:0] dv,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input logic eov, input int lat);
        int cyc;
        exp_t e;
        wait_ready();
        in_valid = 1'b1;
        dividend = n;
        divisor  = dv;
        e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat));
    endtask

    task automatic wait_handoff();
        int n = 0;
        while (out_valid && n < 50) begin
            tick();
            n++;
        end
        if (out_valid) check("handoff_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient",  32'(quotient),  32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags",     32'({div_zero, ovf}), 32'd0);
        reset = 1'b0;
        tick();

        // Exhaustive inverse of the 4x4 multiplier
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(8'(a * b), 4'(b), 4'(a), 4'd0, 1'b0, 1'b0, W);
                wait_handoff();
                check("ready_after_handoff", 32'(in_ready), 32'd1);
            end
        end

        // Normal remainders
        run_op(8'h63, 4'h7, 4'hE, 4'h1, 1'b0, 1'b0, W); wait_handoff();
        run_op(8'hE1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, W); wait_handoff();
        run_op(8'h0A, 4'h3, 4'h3, 4'h1, 1'b0, 1'b0, W); wait_handoff();

        // Exceptions
        run_op(8'h50, 4'h5, 4'hF, 4'h0, 1'b0, 1'b1, 1); wait_handoff();
        run_op(8'h12, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 1); wait_handoff();

        // Backpressure with a competing request held during DONE
        out_ready = 1'b0;
        run_op(8'h8F, 4'hB, 4'hD, 4'h0, 1'b0, 1'b0, W);
        in_valid = 1'b1;
        dividend = 8'h0A;
        divisor  = 4'h3;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_quotient",  32'(quotient),  32'hD);
            check("bp_remainder", 32'(remainder), 32'h0);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            tick();
        end
        begin
            exp_t e;
            out_ready = 1'b1;
            tick();
            check("hs_out_valid", 32'(out_valid), 32'd0);
            check("hs_in_ready",  32'(in_ready),  32'd1);
            e.q = 4'h3; e.r = 4'h1; e.dz = 1'b0; e.ov = 1'b0;
            exp_q.push_back(e);
            tick();
            in_valid = 1'b0;
            check("b2b_accepted", 32'(in_ready), 32'd0);
            wait_handoff();
            for (int i = 0; i < 10 && !out_valid; i++) tick();
            check("b2b_out_valid", 32'(out_valid), 32'd1);
            wait_handoff();
        end

        // Reset mid-CALC discards the operation
        wait_ready();
        in_valid = 1'b1;
        dividend = 8'h63;
        divisor  = 4'h7;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_quotient",  32'(quotient),  32'd0);
        check("mid_rst_remainder", 32'(remainder), 32'd0);
        check("mid_rst_flags",     32'({div_zero, ovf}), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("aborted_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(8'h2D, 4'h5, 4'h9, 4'h0, 1'b0, 1'b0, W);
        wait_handoff();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
